// File: rtl/cen_period_monitor.sv
// Observes a single-cycle clock-enable stream, measures the idle clocks between
// enables, declares lock after LOCK_COUNT equal intervals and flags enable loss.
module cen_period_monitor #(
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cen,
  input  logic [31:0] i32_timeout,
  output logic [31:0] o32_period,
  output logic        or_period_valid,
  output logic        or_locked,
  output logic        or_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic [7:0]  match_q, match_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
  logic        timeout_q, timeout_d;

  logic [32:0] cnt_inc;
  logic        tmo_hit;
  logic        same_period;
  logic [7:0]  match_next;
  logic        lock_hit;

  // Extra bit keeps the threshold compare and the saturation test overflow-free.
  assign cnt_inc     = {1'b0, cnt_q} + 33'd1;
  assign tmo_hit     = (i32_timeout != 32'd0) && (cnt_inc >= {1'b0, i32_timeout});
  assign same_period = (cnt_q == period_q) && (match_q != 8'd0);
  assign match_next  = !same_period        ? 8'd1 :
                       (match_q >= LOCK_N) ? LOCK_N : match_q + 8'd1;
  assign lock_hit    = (match_next >= LOCK_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      match_q   <= match_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_cen) state_d = S_MEASURE;
      end
      S_MEASURE, S_LOCKED: begin
        if (i_cen)        state_d = lock_hit ? S_LOCKED : S_MEASURE;
        else if (tmo_hit) state_d = S_TIMEOUT;
      end
      S_TIMEOUT: begin
        if (i_cen) state_d = S_MEASURE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    period_d  = period_q;
    match_d   = match_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_MEASURE, S_LOCKED: begin
        if (i_cen) begin
          cnt_d    = '0;
          period_d = cnt_q;
          valid_d  = 1'b1;
          match_d  = match_next;
          locked_d = lock_hit;
        end else begin
          cnt_d = cnt_inc[32] ? cnt_q : cnt_inc[31:0];
          if (tmo_hit) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
          end
        end
      end
      S_TIMEOUT: begin
        // The outage interval is thrown away; this enable only re-arms.
        if (i_cen) begin
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign o32_period      = period_q;
  assign or_period_valid = valid_q;
  assign or_locked       = locked_q;
  assign or_timeout      = timeout_q;

endmodule

// File: tb/tb_cen_period_monitor.sv
// Directed bench for cen_period_monitor: a time-stamp based reference model
// checked every cycle, plus hand-computed checkpoints along the way.
module tb_cen_period_monitor;

  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_cen = 1'b0;
  logic [31:0] i32_timeout = 32'd0;
  logic [31:0] o32_period;
  logic        or_period_valid;
  logic        or_locked;
  logic        or_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  cen_period_monitor #(.LOCK_COUNT(LOCK)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cen           (i_cen),
    .i32_timeout     (i32_timeout),
    .o32_period      (o32_period),
    .or_period_valid (or_period_valid),
    .or_locked       (or_locked),
    .or_timeout      (or_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: works from the cycle index of the last enable rather
  // than a running counter.
  longint      cyc = 0;
  longint      last_cen = 0;
  bit          armed = 0;
  bit          in_tmo = 0;
  int          match = 0;
  logic [31:0] e_period = '0;
  logic        e_valid = 1'b0;
  logic        e_locked = 1'b0;
  logic        e_timeout = 1'b0;

  always @(posedge clk) begin
    longint iv;
    cyc++;
    e_valid = 1'b0;
    if (rst) begin
      armed = 0; in_tmo = 0; match = 0;
      e_period = '0; e_locked = 1'b0; e_timeout = 1'b0;
    end else if (i_cen) begin
      if (armed && !in_tmo) begin
        iv = cyc - last_cen - 1;
        if (match > 0 && iv == longint'(e_period)) match++;
        else match = 1;
        e_period = iv[31:0];
        e_valid  = 1'b1;
        e_locked = (match >= LOCK);
      end
      armed = 1; in_tmo = 0; e_timeout = 1'b0;
      last_cen = cyc;
    end else if (armed && !in_tmo && i32_timeout != 0 &&
                 (cyc - last_cen) >= longint'(i32_timeout)) begin
      in_tmo = 1; e_timeout = 1'b1; e_locked = 1'b0; match = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("period",  o32_period,             e_period);
      chk("valid",   32'(or_period_valid),   32'(e_valid));
      chk("locked",  32'(or_locked),         32'(e_locked));
      chk("timeout", 32'(or_timeout),        32'(e_timeout));
    end
  end

  task automatic idle(input int n);
    i_cen = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse();
    i_cen = 1'b1;
    @(posedge clk); #1;
    i_cen = 1'b0;
  endtask

  // n enables, each preceded by gap-1 idle clocks.
  task automatic stream(input int gap, input int n);
    repeat (n) begin
      idle(gap - 1);
      pulse();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},  o32_period,           32'd0);
    chk({tag, "_valid"},   32'(or_period_valid), 32'd0);
    chk({tag, "_locked"},  32'(or_locked),       32'd0);
    chk({tag, "_timeout"}, 32'(or_timeout),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk_zero("reset");

    // steady stream P=3
    stream(4, 5);
    chk("steady_period", o32_period, 32'd3);
    chk("steady_valid",  32'(or_period_valid), 32'd1);
    chk("steady_locked", 32'(or_locked), 32'd1);
    stream(4, 1);
    chk("steady_hold", 32'(or_locked), 32'd1);

    // rate change to P=5
    stream(6, 1);
    chk("rate_period", o32_period, 32'd5);
    chk("rate_unlock", 32'(or_locked), 32'd0);
    stream(6, 2);
    chk("rate_3rd", 32'(or_locked), 32'd0);
    stream(6, 1);
    chk("rate_relock", 32'(or_locked), 32'd1);

    // timeout of 10 clocks after locking at P=3
    i32_timeout = 32'd10;
    stream(4, 4);
    chk("tmo_prelock", 32'(or_locked), 32'd1);
    idle(9);
    chk("tmo_early", 32'(or_timeout), 32'd0);
    idle(1);
    chk("tmo_set",    32'(or_timeout), 32'd1);
    chk("tmo_unlock", 32'(or_locked),  32'd0);
    idle(5);
    pulse();
    chk("tmo_clear",   32'(or_timeout),      32'd0);
    chk("tmo_novalid", 32'(or_period_valid), 32'd0);
    stream(4, 1);
    chk("tmo_resume_valid",  32'(or_period_valid), 32'd1);
    chk("tmo_resume_period", o32_period,           32'd3);

    // back-to-back enables
    i32_timeout = 32'd0;
    do_reset();
    stream(1, 6);
    chk("b2b_period", o32_period, 32'd0);
    chk("b2b_locked", 32'(or_locked), 32'd1);

    // enable lands exactly on the timeout threshold
    do_reset();
    i32_timeout = 32'd4;
    stream(4, 6);
    chk("edge_locked",  32'(or_locked),  32'd1);
    chk("edge_timeout", 32'(or_timeout), 32'd0);

    // reset while locked
    do_reset();
    chk_zero("midrst");
    stream(4, 4);
    chk("midrst_4", 32'(or_locked), 32'd0);
    stream(4, 1);
    chk("midrst_5", 32'(or_locked), 32'd1);

    // lowering the timeout below the running count
    i32_timeout = 32'd0;
    idle(20);
    chk("dyn_hold", 32'(or_locked), 32'd1);
    i32_timeout = 32'd5;
    idle(1);
    chk("dyn_tmo",    32'(or_timeout), 32'd1);
    chk("dyn_unlock", 32'(or_locked),  32'd0);

    do_reset();
    idle(3);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cen_period_monitor.md
Name: cen_period_monitor

Overview:
- Receive-side counterpart of the clock-enable generator: observes a single-cycle clock-enable pulse stream and recovers its prescaler value.
- Measures the clocks between successive enables, declares lock after a run of identical intervals, and flags loss of the enable stream with a programmable timeout.
- Sits beside filter/sampling datapaths to confirm that the sample-rate enable is present and stable before data is trusted.

Parameters:
- LOCK_COUNT, 4, number of consecutive equal intervals required to assert lock (legal range 2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_cen  in  1  monitored clock-enable stream, one-cycle pulses
- i32_timeout  in  32  clocks without an enable before timeout is declared; 0 disables the timeout
- o32_period  out  32  last measured interval, in prescaler units (idle clocks between two enables)
- or_period_valid  out  1  one-cycle pulse when o32_period updates
- or_locked  out  1  high while the stream is stable at o32_period
- or_timeout  out  1  high from timeout detection until the next enable or reset

Behaviour:
- Reset (rst=1 at a clk edge):
  - o32_period=0; or_period_valid=0; or_locked=0; or_timeout=0.
  - Internal counter=0; match count=0; state=IDLE.
  - Reset overrides all other inputs in the same cycle.
- Interval counter:
  - Cleared to 0 on every cycle with i_cen=1.
  - Otherwise increments by 1 per clock in MEASURE and LOCKED, saturating at 32'hFFFFFFFF with no wrap.
  - Value at an enable = number of non-enable cycles since the previous enable.
  - A generator with prescaler P therefore measures P. Back-to-back enables measure 0.
- States:
  - IDLE: counter held at 0. On i_cen go to MEASURE. No period output.
  - MEASURE, on each i_cen:
    - o32_period <= counter; or_period_valid pulses.
    - If counter == o32_period and match count > 0, match count increments; otherwise match count = 1.
    - When match count reaches LOCK_COUNT: go to LOCKED, or_locked=1.
  - LOCKED, on each i_cen:
    - o32_period <= counter; or_period_valid pulses.
    - On mismatch: or_locked=0, match count=1, go to MEASURE. o32_period takes the new value.
  - TIMEOUT:
    - Counter held. or_timeout=1, or_locked=0, match count=0.
    - On i_cen: or_timeout=0, counter=0, go to MEASURE. The interval spanning the outage is discarded (no valid pulse).
- Timeout detection:
  - Applies in MEASURE and LOCKED when i32_timeout != 0 and i_cen=0.
  - Counter+1 >= i32_timeout → enter TIMEOUT, assert or_timeout, drop or_locked.
  - If i_cen=1 in the same cycle, the enable wins: a normal measurement is made and no timeout occurs.
- Latency:
  - All outputs are registered.
  - o32_period, or_period_valid and the or_locked change appear on the clock after the i_cen cycle.
  - or_timeout appears on the clock after the cycle in which the counter reaches i32_timeout.
- Dynamic input: i32_timeout is sampled every cycle. Lowering it below the running count triggers timeout on the next non-enable cycle.
- Reset mid-operation: immediate return to IDLE. The first enable after reset only arms measurement.

Test Plan:
- Steady stream, LOCK_COUNT=4, i32_timeout=0, i_cen pulses every 4 clocks (P=3):
  - 1st enable arms, no valid.
  - Enables 2..5 each produce a valid pulse with o32_period=3.
  - or_locked rises one clock after enable 5 and stays high.
- Rate change after lock, enables switch to every 6 clocks:
  - First new interval gives o32_period=5 and or_locked=0.
  - Lock returns one clock after the 4th consecutive interval of 5.
- Timeout, lock at P=3, i32_timeout=10, enables stop:
  - or_timeout=1 and or_locked=0, 10 clocks after the last enable.
  - Next enable clears or_timeout with no valid pulse.
  - Following enable yields a valid period.
- Back-to-back enables (i_cen held high for 6 cycles): o32_period=0 valid each cycle from the second enable; lock after 4 intervals.
- Enable coincident with timeout threshold:
  - i32_timeout=4 with P=3; enables arrive exactly when counter+1 reaches 4.
  - or_timeout never asserts; lock achieved.
- Reset asserted while locked:
  - All outputs 0 on the next clock.
  - The next enable produces no valid pulse; lock needs 5 more enables.
